// File: rtl/apb_perimetr_ctrl_pkg.sv
// Shared types and defaults for the APB perimeter controller.
// States, default register addresses and the default PREADY timeout.
package apb_perim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WA_SETUP,
    WA_ACCESS,
    WB_SETUP,
    WB_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] DEF_A_ADDR         = 32'h0;
  localparam logic [31:0] DEF_B_ADDR         = 32'h4;
  localparam logic [31:0] DEF_RES_ADDR       = 32'h8;
  localparam int          DEF_TIMEOUT_CYCLES = 16;

  function automatic logic is_access(state_t s);
    return (s == WA_ACCESS) || (s == WB_ACCESS) || (s == RD_ACCESS);
  endfunction

endpackage

// File: rtl/apb_perimetr_ctrl_if.sv
// APB bus between the perimeter controller (master) and the peripheral (slave).
interface apb_perimetr_ctrl_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_perimetr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; last_grant names the most recent winner
// and resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (grant[0])
      last_grant <= 1'b0;
    else if (grant[1])
      last_grant <= 1'b1;
  end

endmodule

// File: rtl/apb_perimetr_ctrl.sv
// APB sequencer: arbitrates two side-pair requesters, writes a/b, reads the result.
// Optional PREADY timeout is enabled with `define APB_PERIM_TIMEOUT_EN.
module apb_perimetr_ctrl
  import apb_perim_pkg::*;
#(
  parameter logic [31:0] A_ADDR         = DEF_A_ADDR,
  parameter logic [31:0] B_ADDR         = DEF_B_ADDR,
  parameter logic [31:0] RES_ADDR       = DEF_RES_ADDR,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req0_valid,
  input  logic [31:0]                req0_a,
  input  logic [31:0]                req0_b,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [31:0]                req1_a,
  input  logic [31:0]                req1_b,
  output logic                       req1_ready,
  output logic                       rsp0_valid,
  output logic [31:0]                rsp0_data,
  output logic                       rsp0_err,
  input  logic                       rsp0_ready,
  output logic                       rsp1_valid,
  output logic [31:0]                rsp1_data,
  output logic                       rsp1_err,
  input  logic                       rsp1_ready,
  apb_perimetr_ctrl_if.master        apb
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, next;
  logic [1:0]  grant;
  logic        owner;
  logic        take;
  logic        timeout;
  logic        err_q;
  logic        rsp_ack;
  logic [31:0] a_q, b_q, data_q;

  // Arbitration is only live in IDLE and never while reset is held.
  rr_arb2 u_arb (
    .clk        (PCLK),
    .rst        (PRESET),
    .req        ({req1_valid, req0_valid}),
    .en         ((state == IDLE) && !PRESET),
    .grant      (grant),
    .last_grant (owner)
  );

  assign take       = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_ack    = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
    end else begin
      state <= next;
      if (take) begin
        a_q    <= grant[1] ? req1_a : req0_a;
        b_q    <= grant[1] ? req1_b : req0_b;
        data_q <= '0;
      end else if (state == RD_ACCESS && apb.PREADY) begin
        data_q <= apb.PRDATA;
      end else if (timeout) begin
        data_q <= '0;
      end
    end
  end

`ifdef APB_PERIM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Counter is zero on entry to every access state and counts stalled cycles.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (!is_access(state))
        cnt <= '0;
      else if (!apb.PREADY)
        cnt <= cnt + 1'b1;
      if (take)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end

  assign timeout = is_access(state) && !apb.PREADY && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_comb begin
    next        = state;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    case (state)
      IDLE: if (take) next = WA_SETUP;
      WA_SETUP, WA_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == WA_ACCESS);
        apb.PWRITE  = 1'b1;
        apb.PADDR   = A_ADDR;
        apb.PWDATA  = a_q;
        if (state == WA_SETUP)  next = WA_ACCESS;
        else if (apb.PREADY)    next = WB_SETUP;
        else if (timeout)       next = RESP;
      end
      WB_SETUP, WB_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == WB_ACCESS);
        apb.PWRITE  = 1'b1;
        apb.PADDR   = B_ADDR;
        apb.PWDATA  = b_q;
        if (state == WB_SETUP)  next = WB_ACCESS;
        else if (apb.PREADY)    next = RD_SETUP;
        else if (timeout)       next = RESP;
      end
      RD_SETUP, RD_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == RD_ACCESS);
        apb.PADDR   = RES_ADDR;
        if (state == RD_SETUP)  next = RD_ACCESS;
        else if (apb.PREADY)    next = RESP;
        else if (timeout)       next = RESP;
      end
      RESP: if (rsp_ack) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Only the owner of the current transaction ever sees a response.
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp0_data  = rsp0_valid ? data_q : '0;
  assign rsp1_data  = rsp1_valid ? data_q : '0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_apb_perimetr_ctrl.sv
// Directed bench for apb_perimetr_ctrl with a behavioural perimeter peripheral.
module tb_apb_perimetr_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_ready, rsp1_ready;
  logic        no_ready;
  int          vectors = 0;
  int          miscompares = 0;

  apb_perimetr_ctrl_if apb ();

  apb_perimetr_ctrl dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .rsp1_ready (rsp1_ready),
    .apb        (apb)
  );

  always #5 PCLK = ~PCLK;

  // Peripheral: one wait state per access, result = 2*(a+b) mod 2^32.
  logic        seen;
  logic [31:0] reg_a, reg_b;
  logic [64:0] log_q[$];

  assign apb.PREADY = apb.PSEL && apb.PENABLE && seen && !no_ready;
  assign apb.PRDATA = 32'((reg_a + reg_b) << 1);

  always @(posedge PCLK) begin
    if (PRESET) begin
      seen  <= 1'b0;
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      seen <= apb.PSEL && apb.PENABLE && !apb.PREADY;
      if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
        log_q.push_back({apb.PWRITE, apb.PADDR, apb.PWDATA});
        if (apb.PWRITE && apb.PADDR == 32'h0) reg_a <= apb.PWDATA;
        if (apb.PWRITE && apb.PADDR == 32'h4) reg_b <= apb.PWDATA;
      end
    end
  end

  task automatic test_reset();
    PRESET = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20;
    repeat (2) begin
      @(posedge PCLK); #1;
      vectors++;
      if ({req0_ready, req1_ready, apb.PSEL, apb.PENABLE, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs got ready=%b%b psel=%b rsp_valid=%b%b expected all 0",
                 req1_ready, req0_ready, apb.PSEL, rsp1_valid, rsp0_valid);
      end
    end
    PRESET = 1'b0;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_first_grant got ready=%b expected 01", {req1_ready, req0_ready});
    end
  endtask

  task automatic test_contention();
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 40 && rsp0_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd6 || rsp1_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL contention_rsp0 got valid=%b data=%0d rsp1_valid=%b expected 1/6/0",
               rsp0_valid, rsp0_data, rsp1_valid);
    end
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL contention_rr_grant got ready=%b expected 10", {req1_ready, req0_ready});
    end
    @(posedge PCLK); #1;
    req1_valid = 1'b0;
    for (int i = 0; i < 40 && rsp1_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd60 || rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL contention_rsp1 got valid=%b data=%0d rsp0_valid=%b expected 1/60/0",
               rsp1_valid, rsp1_data, rsp0_valid);
    end
    rsp1_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp1_ready = 1'b0;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL contention_req0_again got ready=%b expected 1", req0_ready);
    end
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 40 && rsp0_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd16) begin
      miscompares++;
      $display("[TB] FAIL contention_rsp0_second got valid=%b data=%0d expected 1/16", rsp0_valid, rsp0_data);
    end
    rsp0_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [64:0] exp_log [3];
    exp_log[0] = {1'b1, 32'h0, 32'd3};
    exp_log[1] = {1'b1, 32'h4, 32'd5};
    exp_log[2] = {1'b0, 32'h8, 32'd0};
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_accept got ready=%b expected 1", req0_ready);
    end
    log_q.delete();
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    repeat (8) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_early_rsp got valid=%b at T+9 expected 0", rsp0_valid);
    end
    @(posedge PCLK); #1;
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd16 || rsp0_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp got valid=%b data=%0d err=%b at T+10 expected 1/16/0",
               rsp0_valid, rsp0_data, rsp0_err);
    end
    vectors++;
    if (log_q.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL single_apb_count got %0d transfers expected 3", log_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < log_q.size()) begin
        vectors++;
        if (log_q[i] !== exp_log[i]) begin
          miscompares++;
          $display("[TB] FAIL single_apb_xfer%0d got %h expected %h", i, log_q[i], exp_log[i]);
        end
      end
    end
    rsp0_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
    vectors++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_clear got valid=%b data=%0d expected 0/0", rsp0_valid, rsp0_data);
    end
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd9;
    for (int i = 0; i < 40 && rsp0_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    repeat (5) begin
      vectors++;
      if ({rsp0_valid, rsp0_data, rsp0_err, apb.PSEL, req0_ready, req1_ready, rsp1_valid} !== {1'b1, 32'd0, 5'b00000}) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold got valid=%b data=%h psel=%b ready=%b%b expected 1/0/0/00",
                 rsp0_valid, rsp0_data, apb.PSEL, req1_ready, req0_ready);
      end
      @(posedge PCLK); #1;
    end
    rsp0_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL backpressure_next_grant got req1_ready=%b expected 1", req1_ready);
    end
    @(posedge PCLK); #1;
    req1_valid = 1'b0;
    for (int i = 0; i < 40 && rsp1_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd32) begin
      miscompares++;
      $display("[TB] FAIL backpressure_rsp1 got valid=%b data=%0d expected 1/32", rsp1_valid, rsp1_data);
    end
    rsp1_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp1_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic hit, stray;
    hit = 1'b0;
    stray = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6;
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      hit = apb.PSEL && apb.PENABLE && apb.PWRITE && apb.PADDR == 32'h4;
      if (!hit) begin @(posedge PCLK); #1; end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("[TB] FAIL midreset_reach_wb got no WB access phase expected one within 20 cycles");
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    vectors++;
    if (apb.PSEL !== 1'b0 || rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_abort got psel=%b rsp0_valid=%b expected 0/0", apb.PSEL, rsp0_valid);
    end
    repeat (12) begin
      @(posedge PCLK); #1;
      if (rsp0_valid || rsp1_valid || apb.PSEL) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet got activity=%b after reset expected 0", stray);
    end
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2;
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 40 && rsp0_valid !== 1'b1; i++) begin @(posedge PCLK); #1; end
    vectors++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd8) begin
      miscompares++;
      $display("[TB] FAIL midreset_followup got valid=%b data=%0d expected 1/8", rsp0_valid, rsp0_data);
    end
    rsp0_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
  endtask

`ifdef APB_PERIM_TIMEOUT_EN
  task automatic test_timeout();
    no_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    @(posedge PCLK); #1;
    req0_valid = 1'b0;
    repeat (16) begin @(posedge PCLK); #1; end
    vectors++;
    if (apb.PSEL !== 1'b1 || rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_early got psel=%b rsp0_valid=%b at 16th access cycle expected 1/0",
               apb.PSEL, rsp0_valid);
    end
    @(posedge PCLK); #1;
    vectors++;
    if (apb.PSEL !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL timeout_rsp got psel=%b valid=%b err=%b data=%h expected 0/1/1/0",
               apb.PSEL, rsp0_valid, rsp0_err, rsp0_data);
    end
    rsp0_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp0_ready = 1'b0;
    no_ready = 1'b0;
  endtask
`endif

  initial begin
    no_ready   = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_mid_reset();
`ifdef APB_PERIM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
